// File: rtl/bbox_accumulator_pkg.sv
// bbox_accumulator_pkg
//   Shared definitions for the bounding-box accumulator:
//   - WORD_SIZE / FRAME_WIDTH : default label and coordinate widths
//   - DEFAULT_NUM_LABELS      : default number of tracked labels
//   - DEFAULT_MIN_COUNT       : default minimum pixel count for a record
//   - bbox_state_t            : FSM state encoding (BBOX_ACCUM, BBOX_FLUSH)
package bbox_accumulator_pkg;

    localparam int WORD_SIZE          = 8;
    localparam int FRAME_WIDTH        = 11;
    localparam int DEFAULT_NUM_LABELS = 64;
    localparam int DEFAULT_MIN_COUNT  = 4;

    typedef enum logic {
        BBOX_ACCUM = 1'b0,
        BBOX_FLUSH = 1'b1
    } bbox_state_t;

endpackage

// File: rtl/bbox_entry.sv
// bbox_entry
//   Storage for one label: seen flag, bounding box and saturating pixel count.
//   Ports:
//     clk, reset        : clock, asynchronous active-high reset
//     load              : first pixel of this label in the frame (box = point)
//     update            : further pixel, widen box and bump count
//     clear             : drop the seen flag for the next frame
//     x, y              : pixel location
//     seen              : entry holds valid data for this frame
//     x_min .. y_max    : bounding box
//     count             : pixel count, saturating at all-ones
module bbox_entry
    import bbox_accumulator_pkg::*;
#(
    parameter int COORD_WIDTH = FRAME_WIDTH,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   update,
    input  logic                   clear,
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    output logic                   seen,
    output logic [COORD_WIDTH-1:0] x_min,
    output logic [COORD_WIDTH-1:0] x_max,
    output logic [COORD_WIDTH-1:0] y_min,
    output logic [COORD_WIDTH-1:0] y_max,
    output logic [COUNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen  <= 1'b0;
            x_min <= '0;
            x_max <= '0;
            y_min <= '0;
            y_max <= '0;
            count <= '0;
        end else if (clear) begin
            // Box contents are left stale; seen alone decides validity.
            seen <= 1'b0;
        end else if (load) begin
            seen  <= 1'b1;
            x_min <= x;
            x_max <= x;
            y_min <= y;
            y_max <= y;
            count <= COUNT_WIDTH'(1);
        end else if (update) begin
            if (x < x_min) x_min <= x;
            if (x > x_max) x_max <= x;
            if (y < y_min) y_min <= y;
            if (y > y_max) y_max <= y;
            if (count != '1) count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bbox_accumulator.sv
// bbox_accumulator
//   Accumulates a bounding box and pixel count per non-zero label over a frame,
//   then streams one record per live label at end of frame.
//   Ports:
//     clk, reset      : clock, asynchronous active-high reset
//     en              : pixel valid (qualifies vsync, x, y, label)
//     vsync           : frame sync, rising edge (sampled on en) ends the frame
//     x, y, label     : pixel location and component label (0 = background)
//     out_valid/ready : record handshake
//     out_label, out_x_min, out_x_max, out_y_min, out_y_max, out_count : record
//     frame_done      : one-cycle pulse after the last record of a frame
//     busy            : high while flushing
//     overrun         : sticky, input activity seen while flushing
//     state_dbg       : current FSM state
//
//   Handshake: a record transfers on a cycle where out_valid && out_ready.
//   Once out_valid is high it stays high, with the payload unchanged, until
//   that transfer; out_ready while out_valid is low is ignored.
module bbox_accumulator
    import bbox_accumulator_pkg::*;
#(
    parameter int LABEL_WIDTH = WORD_SIZE,
    parameter int NUM_LABELS  = DEFAULT_NUM_LABELS,
    parameter int COORD_WIDTH = FRAME_WIDTH,
    parameter int COUNT_WIDTH = 16,
    parameter int MIN_COUNT   = DEFAULT_MIN_COUNT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   vsync,
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    input  logic [LABEL_WIDTH-1:0] label,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LABEL_WIDTH-1:0] out_label,
    output logic [COORD_WIDTH-1:0] out_x_min,
    output logic [COORD_WIDTH-1:0] out_x_max,
    output logic [COORD_WIDTH-1:0] out_y_min,
    output logic [COORD_WIDTH-1:0] out_y_max,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   overrun,
    output bbox_state_t            state_dbg
);

    localparam int IDX_W = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1;

    bbox_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vsync_q;
    logic             vsync_edge;
    logic             pix_ok;
    logic             clear_all;
    logic             load_payload;
    logic             advance;
    logic             out_valid_d;
    logic             frame_done_d;
    logic             overrun_d;
    logic             qualifies;

    logic [NUM_LABELS-1:0]  e_seen;
    logic [COORD_WIDTH-1:0] e_x_min [NUM_LABELS];
    logic [COORD_WIDTH-1:0] e_x_max [NUM_LABELS];
    logic [COORD_WIDTH-1:0] e_y_min [NUM_LABELS];
    logic [COORD_WIDTH-1:0] e_y_max [NUM_LABELS];
    logic [COUNT_WIDTH-1:0] e_count [NUM_LABELS];

    assign vsync_edge = en && vsync && !vsync_q;
    assign pix_ok     = (state_q == BBOX_ACCUM) && en && (label != '0) &&
                        (32'(label) < 32'(NUM_LABELS));

    for (genvar i = 0; i < NUM_LABELS; i++) begin : g_entry
        logic hit;
        assign hit = pix_ok && (label == LABEL_WIDTH'(i));

        bbox_entry #(
            .COORD_WIDTH(COORD_WIDTH),
            .COUNT_WIDTH(COUNT_WIDTH)
        ) u_entry (
            .clk   (clk),
            .reset (reset),
            .load  (hit && !e_seen[i]),
            .update(hit && e_seen[i]),
            .clear (clear_all),
            .x     (x),
            .y     (y),
            .seen  (e_seen[i]),
            .x_min (e_x_min[i]),
            .x_max (e_x_max[i]),
            .y_min (e_y_min[i]),
            .y_max (e_y_max[i]),
            .count (e_count[i])
        );
    end

    assign qualifies = e_seen[idx_q] && (e_count[idx_q] >= COUNT_WIDTH'(MIN_COUNT));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        out_valid_d  = out_valid;
        frame_done_d = 1'b0;
        overrun_d    = overrun;
        clear_all    = 1'b0;
        load_payload = 1'b0;
        advance      = 1'b0;
        case (state_q)
            BBOX_ACCUM: begin
                // The edge pixel itself is accumulated by the entries this cycle.
                if (vsync_edge) begin
                    state_d   = BBOX_FLUSH;
                    idx_d     = IDX_W'(1);
                    overrun_d = 1'b0;
                end
            end
            BBOX_FLUSH: begin
                if ((en && label != '0) || vsync_edge) overrun_d = 1'b1;
                if (out_valid) begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        advance     = 1'b1;
                    end
                end else if (qualifies) begin
                    load_payload = 1'b1;
                    out_valid_d  = 1'b1;
                end else begin
                    advance = 1'b1;
                end
                if (advance) begin
                    if (idx_q == IDX_W'(NUM_LABELS - 1)) begin
                        state_d      = BBOX_ACCUM;
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        clear_all    = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = BBOX_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BBOX_ACCUM;
            idx_q      <= '0;
            vsync_q    <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            out_label  <= '0;
            out_x_min  <= '0;
            out_x_max  <= '0;
            out_y_min  <= '0;
            out_y_max  <= '0;
            out_count  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_valid  <= out_valid_d;
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
            if (en) vsync_q <= vsync;
            if (load_payload) begin
                out_label <= LABEL_WIDTH'(idx_q);
                out_x_min <= e_x_min[idx_q];
                out_x_max <= e_x_max[idx_q];
                out_y_min <= e_y_min[idx_q];
                out_y_max <= e_y_max[idx_q];
                out_count <= e_count[idx_q];
            end
        end
    end

    assign busy      = (state_q == BBOX_FLUSH);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bbox_accumulator.sv
// tb_bbox_accumulator
//   Two accumulators share one input stream: dut_a suppresses records below
//   4 pixels, dut_b reports every live label. Count width is 10 bits so that
//   saturation is reached quickly.
module tb_bbox_accumulator;
  import bbox_accumulator_pkg::*;

  localparam int LW = 8;
  localparam int CW = 11;
  localparam int NW = 10;
  localparam int NL = 64;
  localparam int RW = LW + 4 * CW + NW;
  localparam int CNT_MAX = (1 << NW) - 1;
  localparam int MIN_A = 4;
  localparam int MIN_B = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic en, vsync, out_ready;
  logic [CW-1:0] x, y;
  logic [LW-1:0] label;

  always #5 clk = ~clk;

  logic out_valid_a, frame_done_a, busy_a, overrun_a;
  logic [LW-1:0] out_label_a;
  logic [CW-1:0] out_x_min_a, out_x_max_a, out_y_min_a, out_y_max_a;
  logic [NW-1:0] out_count_a;
  bbox_state_t state_a;

  logic out_valid_b, frame_done_b, busy_b, overrun_b;
  logic [LW-1:0] out_label_b;
  logic [CW-1:0] out_x_min_b, out_x_max_b, out_y_min_b, out_y_max_b;
  logic [NW-1:0] out_count_b;
  bbox_state_t state_b;

  bbox_accumulator #(.LABEL_WIDTH(LW), .NUM_LABELS(NL), .COORD_WIDTH(CW),
                     .COUNT_WIDTH(NW), .MIN_COUNT(MIN_A)) dut_a (
    .clk(clk), .reset(reset), .en(en), .vsync(vsync), .x(x), .y(y), .label(label),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_label(out_label_a),
    .out_x_min(out_x_min_a), .out_x_max(out_x_max_a), .out_y_min(out_y_min_a),
    .out_y_max(out_y_max_a), .out_count(out_count_a), .frame_done(frame_done_a),
    .busy(busy_a), .overrun(overrun_a), .state_dbg(state_a));

  bbox_accumulator #(.LABEL_WIDTH(LW), .NUM_LABELS(NL), .COORD_WIDTH(CW),
                     .COUNT_WIDTH(NW), .MIN_COUNT(MIN_B)) dut_b (
    .clk(clk), .reset(reset), .en(en), .vsync(vsync), .x(x), .y(y), .label(label),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_label(out_label_b),
    .out_x_min(out_x_min_b), .out_x_max(out_x_max_b), .out_y_min(out_y_min_b),
    .out_y_max(out_y_max_b), .out_count(out_count_b), .frame_done(frame_done_b),
    .busy(busy_b), .overrun(overrun_b), .state_dbg(state_b));

  logic [RW-1:0] pay_a, pay_b;
  assign pay_a = {out_label_a, out_x_min_a, out_x_max_a, out_y_min_a, out_y_max_a, out_count_a};
  assign pay_b = {out_label_b, out_x_min_b, out_x_max_b, out_y_min_b, out_y_max_b, out_count_b};

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q_a[$];
  logic [RW-1:0] exp_q_b[$];
  int exp_frames = 0;
  int fd_cnt[2] = '{0, 0};
  bit stall[2] = '{0, 0};
  logic [RW-1:0] hold[2];
  bit exp_overrun = 0;
  bit ready_hold = 0;

  // ---------------- behavioural model ----------------
  bit m_seen[NL];
  int m_xmin[NL], m_xmax[NL], m_ymin[NL], m_ymax[NL], m_cnt[NL];
  bit model_busy = 0;
  bit vs_prev = 0;

  function automatic logic [RW-1:0] pack_rec(int lab, int xmn, int xmx, int ymn, int ymx, int cnt);
    return {LW'(lab), CW'(xmn), CW'(xmx), CW'(ymn), CW'(ymx), NW'(cnt)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_seen[i] = 0;
  endtask

  task automatic model_pixel(int px, int py, int lab);
    if (lab == 0 || lab >= NL) return;
    if (!m_seen[lab]) begin
      m_seen[lab] = 1;
      m_xmin[lab] = px; m_xmax[lab] = px;
      m_ymin[lab] = py; m_ymax[lab] = py;
      m_cnt[lab] = 1;
    end else begin
      if (px < m_xmin[lab]) m_xmin[lab] = px;
      if (px > m_xmax[lab]) m_xmax[lab] = px;
      if (py < m_ymin[lab]) m_ymin[lab] = py;
      if (py > m_ymax[lab]) m_ymax[lab] = py;
      m_cnt[lab] = (m_cnt[lab] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[lab] + 1;
    end
  endtask

  task automatic model_frame_end();
    for (int i = 1; i < NL; i++) begin
      if (m_seen[i] && m_cnt[i] >= MIN_A)
        exp_q_a.push_back(pack_rec(i, m_xmin[i], m_xmax[i], m_ymin[i], m_ymax[i], m_cnt[i]));
      if (m_seen[i] && m_cnt[i] >= MIN_B)
        exp_q_b.push_back(pack_rec(i, m_xmin[i], m_xmax[i], m_ymin[i], m_ymax[i], m_cnt[i]));
    end
    model_clear();
    exp_frames++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called in the posedge+1 phase; returns in the next posedge+1 phase.
  task automatic drive_pixel(int px, int py, int lab, bit vs);
    bit edge_now;
    en = 1'b1; x = CW'(px); y = CW'(py); label = LW'(lab); vsync = vs;
    @(posedge clk); #1;
    en = 1'b0; label = '0;
    edge_now = vs && !vs_prev;
    vs_prev = vs;
    if (!model_busy) begin
      model_pixel(px, py, lab);
      if (edge_now) begin
        model_frame_end();
        model_busy = 1;
        exp_overrun = 0;
      end
    end else if (lab != 0 || edge_now) begin
      exp_overrun = 1;
    end
  endtask

  task automatic end_frame();
    drive_pixel(0, 0, 0, 1);
    drive_pixel(0, 0, 0, 0);
  endtask

  task automatic wait_frame_done();
    int n = 0;
    while ((fd_cnt[0] < exp_frames || fd_cnt[1] < exp_frames) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL frame_done_timeout: got a=%0d b=%0d expected %0d", fd_cnt[0], fd_cnt[1], exp_frames);
    end
    model_busy = 0;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid_a();
    int n = 0;
    while (!out_valid_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("valid_a_timeout", out_valid_a, 1'b1);
  endtask

  // ---------------- ready driver ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = ready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- compare process ----------------
  task automatic check_dut(input int w, input logic v, input logic [RW-1:0] pay,
                           input logic fd, input logic ov);
    if (stall[w]) begin
      check(w == 0 ? "hold_valid_a" : "hold_valid_b", v, 1'b1);
      check(w == 0 ? "hold_payload_a" : "hold_payload_b", pay, hold[w]);
    end
    if (v && out_ready) begin
      checks++;
      if (w == 0 && exp_q_a.size() == 0 || w == 1 && exp_q_b.size() == 0) begin
        errors++;
        $display("FAIL record_unexpected dut%0d: got %h expected no record", w, pay);
      end else begin
        logic [RW-1:0] e;
        e = (w == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
        if (pay !== e) begin
          errors++;
          $display("FAIL record dut%0d: got %h expected %h", w, pay, e);
        end
      end
    end
    stall[w] = v && !out_ready;
    hold[w] = pay;
    if (fd) begin
      check(w == 0 ? "frame_done_left_a" : "frame_done_left_b",
            (w == 0) ? exp_q_a.size() : exp_q_b.size(), 0);
      fd_cnt[w]++;
    end
    check(w == 0 ? "overrun_a" : "overrun_b", ov, exp_overrun);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall[0] = 0;
        stall[1] = 0;
      end else begin
        check_dut(0, out_valid_a, pay_a, frame_done_a, overrun_a);
        check_dut(1, out_valid_b, pay_b, frame_done_b, overrun_b);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; en = 1'b0; vsync = 1'b0; x = '0; y = '0; label = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {out_valid_a, out_valid_b}, 2'b00);
    check("rst_frame_done", {frame_done_a, frame_done_b}, 2'b00);
    check("rst_busy", {busy_a, busy_b}, 2'b00);
    check("rst_overrun", {overrun_a, overrun_b}, 2'b00);
    check("rst_payload_a", pay_a, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Small box: only the MIN_COUNT=1 instance reports it.
    drive_pixel(10, 5, 3, 0);
    drive_pixel(14, 7, 3, 0);
    drive_pixel(9, 6, 3, 0);
    drive_pixel(0, 0, 0, 0);
    drive_pixel(0, 0, 0, 1);
    check("t1_q_b_size", exp_q_b.size(), 1);
    check("t1_q_b_rec", exp_q_b[0], pack_rec(3, 9, 14, 5, 7, 3));
    check("t1_q_a_size", exp_q_a.size(), 0);
    drive_pixel(0, 0, 0, 0);
    wait_frame_done();

    // Two records, consumer stalled on the first; edge coordinates included.
    ready_hold = 1;
    drive_pixel(0, 0, 2, 0);
    drive_pixel(2047, 3, 2, 0);
    drive_pixel(5, 2047, 2, 0);
    drive_pixel(7, 9, 2, 0);
    for (int i = 0; i < 4; i++) drive_pixel(100, 200, 5, 0);
    end_frame();
    wait_valid_a();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_stall_valid", out_valid_a, 1'b1);
      check("t2_stall_payload", pay_a, pack_rec(2, 0, 2047, 0, 2047, 4));
    end
    @(posedge clk); #1;
    ready_hold = 0;
    wait_frame_done();

    // Out-of-range label ignored; last tracked label reported.
    for (int i = 0; i < 5; i++) drive_pixel(30 + i, 40, 70, 0);
    for (int i = 0; i < 4; i++) drive_pixel(1 + i, 2, 63, 0);
    end_frame();
    wait_frame_done();

    // Count saturation.
    for (int i = 0; i < CNT_MAX + 6; i++) drive_pixel(i, 0, 1, 0);
    drive_pixel(0, 0, 0, 1);
    check("t4_sat_count", exp_q_a[0][NW-1:0], CNT_MAX);
    drive_pixel(0, 0, 0, 0);
    wait_frame_done();

    // Activity during flush sets overrun; next frame starts clean.
    for (int i = 0; i < 4; i++) drive_pixel(20, 20, 4, 0);
    end_frame();
    drive_pixel(1, 1, 9, 0);
    drive_pixel(0, 0, 0, 1);
    drive_pixel(0, 0, 0, 0);
    @(negedge clk);
    check("t5_overrun_a", overrun_a, 1'b1);
    check("t5_overrun_b", overrun_b, 1'b1);
    @(posedge clk); #1;
    wait_frame_done();
    for (int i = 0; i < 4; i++) drive_pixel(50, 60, 9, 0);
    end_frame();
    check("t5_overrun_cleared", {overrun_a, overrun_b}, 2'b00);
    wait_frame_done();

    // Random frames.
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < 40; p++) begin
        int lab;
        lab = $urandom_range(0, 11);
        if ($urandom_range(0, 9) == 0) lab = $urandom_range(60, 90);
        drive_pixel($urandom_range(0, 2047), $urandom_range(0, 2047), lab, 0);
      end
      end_frame();
      wait_frame_done();
    end

    // Reset in the middle of a flush with a record pending.
    ready_hold = 1;
    for (int i = 0; i < 4; i++) drive_pixel(8, 8, 2, 0);
    end_frame();
    wait_valid_a();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", {out_valid_a, out_valid_b}, 2'b00);
    check("t6_rst_busy", {busy_a, busy_b}, 2'b00);
    check("t6_rst_label", out_label_a, 0);
    exp_q_a.delete();
    exp_q_b.delete();
    exp_frames--;
    model_clear();
    model_busy = 0;
    vs_prev = 0;
    exp_overrun = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    ready_hold = 0;
    @(posedge clk); #1;
    end_frame();
    check("t6_empty_q", exp_q_a.size() + exp_q_b.size(), 0);
    wait_frame_done();

    check("frames_a", fd_cnt[0], exp_frames);
    check("frames_b", fd_cnt[1], exp_frames);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
